instruction_fetch_unit: RTL

Fetch stage directly upstream of control_unit_setup. It holds the PC and issues word fetches to instruction memory over a request/response handshake. Returned instructions are buffered in a small in-order FIFO and presented to the control unit with a valid/ready handshake. A branch or redirect from downstream flushes the buffer, drops in-flight responses and restarts fetch at the target.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/instruction_fetch_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int PC_WIDTH   = 64;
  localparam int INST_WIDTH = 32;
  localparam int PC_INCR    = 4;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry;
endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer of fetch entries; flush dominates push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry    push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  fetch_entry      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset: the head is only visible while count is non-zero.
  always_ff @(posedge clock) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC generation, credit-limited memory requests, response buffering
// and redirect flush with stale-response dropping.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH   = fetch_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic                inst_valid,
  output logic [31:0]         instruction,
  output logic [PC_WIDTH-1:0] inst_pc,
  input  logic                inst_ready,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_target
);
  // Handshakes: a transfer happens in a cycle where valid (imem_req / inst_valid)
  // and ready (imem_ready / inst_ready) are both high; valid never waits on ready.
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] resp_pc;
  logic [PC_WIDTH-1:0] target_pc;
  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       drop_cnt;
  logic [CW-1:0]       fifo_count;
  logic [SW-1:0]       avail;
  logic                pop;
  logic                accept;
  logic                drop;
  logic                resp_keep;
  logic                push;
  logic                fifo_full;
  logic                fifo_empty;
  fetch_entry          head;
  fetch_entry          push_data;

  assign target_pc = {redirect_target[PC_WIDTH-1:2], 2'b00};
  assign pop       = inst_valid & inst_ready;
  assign avail     = SW'(FIFO_DEPTH) - {1'b0, outstanding} - {1'b0, fifo_count} + SW'(pop);
  assign imem_req  = reset & ~redirect & (avail != '0);
  assign imem_addr = fetch_pc;
  assign accept    = imem_req & imem_ready;
  assign drop      = imem_rvalid & (drop_cnt != '0);
  assign resp_keep = imem_rvalid & ~drop & ~redirect;
  // The credit rule keeps a kept response from ever meeting a full buffer.
  assign push      = resp_keep & (~fifo_full | pop);

  assign push_data.pc   = resp_pc;
  assign push_data.inst = imem_rdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid);
      if (redirect) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        // outstanding already includes responses still waiting to be dropped,
        // so every in-flight response after this cycle becomes a drop.
        drop_cnt <= outstanding - CW'(imem_rvalid);
      end else begin
        if (accept) fetch_pc <= fetch_pc + PC_WIDTH'(PC_INCR);
        if (push)   resp_pc  <= resp_pc + PC_WIDTH'(PC_INCR);
        if (drop)   drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign inst_valid  = ~fifo_empty;
  assign instruction = inst_valid ? head.inst : '0;
  assign inst_pc     = inst_valid ? head.pc : '0;
endmodule
